ins_fill_queue: RTL
===================

# ins_fill_queue

Line-fill request queue between the instruction cache and the next-level cache. Each cycle the instruction cache may raise one 26-bit line-address fill request (address bits [31:6]). This block buffers the requests in a small FIFO and coalesces duplicates of lines already pending. It then issues them in order to the next-level cache over a valid/ready handshake, and keeps counters for the statistics module.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `ADDR_W`, 26: line address width (address bits [31:6]).
- `CNT_W`, 32: statistics counter width.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state.
- `flush`  in  1  synchronous clear of queue and counters; driven when the trace command is RESET (n = 8).
- `req_valid`  in  1  fill request present this cycle.
- `req_addr`  in  ADDR_W  line address of the request.
- `out_valid`  out  1  head entry valid toward next-level cache.
- `out_addr`  out  ADDR_W  head entry line address.
- `out_ready`  in  1  next-level cache accepts head this cycle.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH)+1  occupied entries.
- `issued`  out  CNT_W  handshakes completed.
- `merged`  out  CNT_W  requests coalesced into a pending entry.
- `dropped`  out  CNT_W  requests lost because the queue was full.

## Operation
- Storage is a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- A pop occurs when out_valid && out_ready; the head advances and `issued` increments.
- On req_valid, req_addr is compared against every valid entry except the head being popped this cycle.
  - Match: no enqueue; `merged` increments.
  - No match, with count < DEPTH or a pop this cycle: write at tail and advance the tail.
  - No match, full, no pop: request discarded; `dropped` increments.
- A simultaneous push and pop leaves count unchanged. At full, a same-cycle pop frees the slot for the push.
- A request matching the head being popped is enqueued as a new entry, not merged.
- `flush` has priority over push and pop in the same cycle. It zeros the pointers, count and all three counters, and ignores that cycle's request and handshake.
- Counters saturate at all-ones and do not wrap.
- out_valid = !empty. out_addr = storage[head]. Both come straight from registers with no combinational path from req_*. out_addr holds the last head value when empty.
- A valid head must stay stable until accepted. The downstream side may hold out_ready high permanently.

## Timing
- Reset (async assert) values: out_valid 0, out_addr 0, full 0, empty 1, count 0, issued 0, merged 0, dropped 0. Pointers and storage are 0.
- Deassertion of rst is synchronous to clk in the surrounding logic. The first request is accepted on the first rising edge with rst low.
- Enqueue-to-issue latency: a request at edge N into an empty queue gives out_valid = 1 after edge N; it can be popped at edge N+1.
- Throughput: one push and one pop per cycle, sustained.
- rst asserted mid-handshake discards all entries immediately, without waiting for clk. No partial counter updates survive.

## Structure
- Package `fill_pkg` holds ADDR_W, CNT_W, the default DEPTH, and a `line_addr_t` typedef (logic [ADDR_W-1:0]). The data cache's fill path reuses these.
- One sub-module, `fill_match`: combinational. Its inputs are the storage array, a per-entry valid mask and req_addr; its output is a match flag. The top module builds the valid mask from head, count and the pop condition.
- The top module holds the pointers, the count, the counters and the saturation logic.

## Test plan
- Reset/idle: assert rst mid-cycle with 2 entries queued -> count 0, empty 1, out_valid 0 at once, before any clk edge.
- Fill and drain:
  - push 0x0000041, 0x0000082, 0x00000C3, 0x0000104 with out_ready = 0 -> full = 1, count = 4.
  - A fifth push of 0x0000145 -> dropped = 1.
  - Then out_ready = 1 -> issued in the order 041, 082, 0C3, 104 on consecutive cycles.
- Coalesce: push 0x1234567 twice with out_ready = 0 -> count = 1, merged = 1. Pushing 0x1234567 in the same cycle it is popped -> re-enqueued, count = 1.
- Full with simultaneous pop: queue full, push 0x3FFFFFF with out_ready = 1 -> count stays 4, dropped unchanged, 0x3FFFFFF becomes the tail.
- Pointer wrap: stream 10 distinct addresses with out_ready held high -> out_addr follows the input one cycle later, issued = 10, no drops.
- Flush priority and saturation:
  - flush together with push and pop -> all counters 0, empty 1.
  - Preload `dropped` to 0xFFFFFFFF through a test hook, then one more drop -> the value stays 0xFFFFFFFF.

Source files
------------

// File: rtl/fill_pkg.sv
// fill_pkg: shared types and constants for the line-fill request queues.
//   ADDR_W      - line address width (address bits [31:6])
//   CNT_W       - statistics counter width
//   FILL_DEPTH  - default queue depth
//   line_addr_t - one line address
//   sat_inc     - saturating increment for statistics counters
package fill_pkg;

  localparam int ADDR_W     = 26;
  localparam int CNT_W      = 32;
  localparam int FILL_DEPTH = 4;

  typedef logic [ADDR_W-1:0] line_addr_t;
  typedef logic [CNT_W-1:0]  stat_cnt_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic stat_cnt_t sat_inc(input stat_cnt_t v);
    return (&v) ? v : v + stat_cnt_t'(1);
  endfunction

endpackage

// File: rtl/fill_match.sv
// fill_match: combinational duplicate detector for the fill queue.
//   i_entries - queue storage array
//   i_valid   - per-entry mask of entries eligible for coalescing
//   i_addr    - incoming request line address
//   o_match   - request equals at least one eligible entry
module fill_match
  import fill_pkg::*;
#(
  parameter int DEPTH = FILL_DEPTH
) (
  input  line_addr_t       i_entries [DEPTH],
  input  logic [DEPTH-1:0] i_valid,
  input  line_addr_t       i_addr,
  output logic             o_match
);

  logic [DEPTH-1:0] w_hit;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign w_hit[gi] = i_valid[gi] && (i_entries[gi] == i_addr);
  end

  assign o_match = |w_hit;

endmodule

// File: rtl/ins_fill_queue.sv
// ins_fill_queue: instruction-cache line-fill request queue with duplicate
// coalescing, in-order valid/ready issue and saturating statistics.
//   clk, rst          - clock, asynchronous active-high reset
//   flush             - synchronous clear of queue and counters
//   req_valid/addr    - fill request from the instruction cache
//   out_valid/addr    - head entry toward the next-level cache (registered)
//   out_ready         - next-level cache accepts the head
//   full/empty/count  - occupancy (registered)
//   issued/merged/dropped - statistics counters
//   tst_load_dropped/tst_dropped_val - test hook that preloads `dropped`
module ins_fill_queue
  import fill_pkg::*;
#(
  parameter int DEPTH = FILL_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   req_valid,
  input  line_addr_t             req_addr,
  output logic                   out_valid,
  output line_addr_t             out_addr,
  input  logic                   out_ready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output stat_cnt_t              issued,
  output stat_cnt_t              merged,
  output stat_cnt_t              dropped,
  input  logic                   tst_load_dropped,
  input  stat_cnt_t              tst_dropped_val
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  line_addr_t        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;
  line_addr_t        r_out_addr;
  stat_cnt_t         r_issued;
  stat_cnt_t         r_merged;
  stat_cnt_t         r_dropped;

  logic              w_pop;
  logic              w_push;
  logic              w_match;
  logic              w_merge;
  logic              w_drop;
  logic [DEPTH-1:0]  w_valid_mask;
  logic [PTR_W-1:0]  w_head_next;
  logic [CW-1:0]     w_count_next;

  assign w_pop = !r_empty && out_ready;

  // An entry is pending when its distance from head is below count. The
  // head leaving this cycle is excluded so a matching request re-enqueues.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
    logic [PTR_W-1:0] w_off;
    assign w_off = PTR_W'(gi) - r_head;
    assign w_valid_mask[gi] = ({1'b0, w_off} < r_count) &&
                              !(w_pop && (PTR_W'(gi) == r_head));
  end

  fill_match #(.DEPTH(DEPTH)) u_match (
    .i_entries (r_mem),
    .i_valid   (w_valid_mask),
    .i_addr    (req_addr),
    .o_match   (w_match)
  );

  assign w_merge = req_valid && w_match;
  assign w_push  = req_valid && !w_match && (!r_full || w_pop);
  assign w_drop  = req_valid && !w_match && r_full && !w_pop;

  assign w_head_next = w_pop ? r_head + PTR_W'(1) : r_head;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_count_next = r_count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (!flush && w_push) begin
      r_mem[r_tail] <= req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_out_addr <= '0;
      r_issued   <= '0;
      r_merged   <= '0;
      r_dropped  <= '0;
    end else if (flush) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_issued  <= '0;
      r_merged  <= '0;
      r_dropped <= '0;
    end else begin
      r_head  <= w_head_next;
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == '0);
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      // Pre-compute the next head word; when the push lands in the slot
      // that becomes head, storage is not written yet, so bypass req_addr.
      // When the queue drains the last head value is held.
      if (w_count_next != '0)
        r_out_addr <= (w_push && (r_tail == w_head_next)) ? req_addr
                                                          : r_mem[w_head_next];
      if (w_pop)   r_issued <= sat_inc(r_issued);
      if (w_merge) r_merged <= sat_inc(r_merged);
      if (tst_load_dropped)
        r_dropped <= tst_dropped_val;
      else if (w_drop)
        r_dropped <= sat_inc(r_dropped);
    end
  end

  assign out_valid = !r_empty;
  assign out_addr  = r_out_addr;
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;
  assign issued    = r_issued;
  assign merged    = r_merged;
  assign dropped   = r_dropped;

endmodule
